aes_stream_ctrl: RTL

- Sequencer in front of AES_engine: installs the 15 round keys from an external key store, then streams plaintext or ciphertext blocks into the engine.
- Enforces that the pipeline is empty before a key reload or an encrypt/decrypt mode change.
- Tracks in-flight blocks and presents each result with its mode tag. The engine pipeline cannot stall, so the output side has no backpressure.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_inflight_tracker.sv | 60 ++++++
 rtl/aes_stream_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES stream sequencer.
//   NUM_KEYS     : number of round keys installed into the engine (slots 0..14)
//   DEF_LATENCY  : default engine latency, eng_is_valid to eng_data_out
//   block_t      : one 128-bit data/key block
//   ctrl_state_t : sequencer states
package aes_pkg;

  localparam int NUM_KEYS    = 15;
  localparam int DEF_LATENCY = 17;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEYLOAD = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/aes_inflight_tracker.sv
// Tracks blocks travelling through the fixed-latency engine.
// A valid/tag shift register mirrors the engine pipeline so the tail stage
// lines up with the matching engine result; a counter gives the number of
// blocks issued but not yet retired.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   issue_i       : block entering the engine this cycle
//   tag_i         : mode tag of the issued block
//   tail_valid_o  : a result leaves the engine this cycle
//   tail_tag_o    : mode tag of that result
//   inflight_o    : blocks issued and not yet retired
module aes_inflight_tracker #(
  parameter int LATENCY = 17,
  parameter int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_i,
  input  logic             tag_i,
  output logic             tail_valid_o,
  output logic             tail_tag_o,
  output logic [CNT_W-1:0] inflight_o
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Advance the shadow pipeline and update the occupancy count
  always_comb begin
    vld_d = {vld_q[LATENCY-2:0], issue_i};
    tag_d = {tag_q[LATENCY-2:0], issue_i & tag_i};
    cnt_d = cnt_q;
    // Issue and retire in the same cycle cancel out
    if (issue_i && !vld_q[LATENCY-1]) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!issue_i && vld_q[LATENCY-1]) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Tracker state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= {LATENCY{1'b0}};
      tag_q <= {LATENCY{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  assign tail_valid_o = vld_q[LATENCY-1];
  assign tail_tag_o   = tag_q[LATENCY-1];
  assign inflight_o   = cnt_q;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Sequencer in front of the AES engine: installs the round keys from an
// external key store, then streams blocks into the engine and tags each
// result with its mode. The pipeline is drained before a key reload or an
// encrypt/decrypt mode change.
//   clk, n_rst                        : clock, asynchronous active-low reset
//   key_start                         : request a (re)load of the round keys
//   key_rd_addr / key_rd_data         : key store read port (1-cycle read)
//   key_done, keys_valid              : key load finished / key set installed
//   in_valid, in_ready, in_data,
//   in_encrypt                        : input block handshake and mode
//   out_valid, out_data, out_encrypt  : results, no backpressure
//   eng_*                             : engine key load and data interface
module aes_stream_ctrl
  import aes_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_start,
  output logic [3:0]   key_rd_addr,
  input  logic [127:0] key_rd_data,
  output logic         key_done,
  output logic         keys_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_encrypt,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic         out_encrypt,
  output logic         eng_load,
  output logic [3:0]   eng_round_number,
  output logic [127:0] eng_key,
  output logic         eng_is_valid,
  output logic [127:0] eng_data_in,
  output logic         eng_encrypt_flag,
  input  logic [127:0] eng_data_out
);

  localparam int         CNT_W     = $clog2(LATENCY + 1);
  localparam logic [3:0] LAST_SLOT = 4'(NUM_KEYS - 1);
  localparam logic [3:0] LOAD_END  = 4'(NUM_KEYS);

  ctrl_state_t      state_q, state_d;
  logic [3:0]       kidx_q, kidx_d;
  logic             mode_q, mode_d;
  logic             keys_valid_q, keys_valid_d;
  logic             key_done_q, key_done_d;
  logic             eng_load_q, eng_load_d;
  logic [3:0]       eng_slot_q, eng_slot_d;
  logic             eng_valid_q, eng_valid_d;
  block_t           eng_data_q, eng_data_d;
  logic             eng_flag_q, eng_flag_d;
  logic             ready_s;
  logic             pipe_empty_s;
  logic             tail_valid_s;
  logic             tail_tag_s;
  logic [CNT_W-1:0] inflight_s;

  // A block accepted last cycle is on eng_is_valid but not yet counted, so
  // it must also hold off mode changes and reloads.
  assign pipe_empty_s = (inflight_s == {CNT_W{1'b0}}) && !eng_valid_q;

  // Sequencer next-state logic and registered engine-side outputs
  always_comb begin
    state_d      = state_q;
    kidx_d       = kidx_q;
    mode_d       = mode_q;
    keys_valid_d = keys_valid_q;
    key_done_d   = 1'b0;
    eng_load_d   = 1'b0;
    eng_slot_d   = 4'd0;
    eng_valid_d  = 1'b0;
    eng_data_d   = 128'd0;
    eng_flag_d   = eng_flag_q;
    ready_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_start) begin
          state_d = KEYLOAD;
          kidx_d  = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      KEYLOAD: begin
        // Address k goes out in cycle k; its data is written one cycle later
        if (kidx_q <= LAST_SLOT) begin
          eng_load_d = 1'b1;
          eng_slot_d = kidx_q;
        end else begin
          eng_load_d = 1'b0;
        end
        if (kidx_q == LAST_SLOT) begin
          key_done_d   = 1'b1;
          keys_valid_d = 1'b1;
        end else begin
          key_done_d = 1'b0;
        end
        if (kidx_q == LOAD_END) begin
          state_d = RUN;
          kidx_d  = 4'd0;
        end else begin
          kidx_d = kidx_q + 4'd1;
        end
      end
      RUN: begin
        ready_s = !key_start && ((in_encrypt == mode_q) || pipe_empty_s);
        if (key_start) begin
          state_d      = DRAIN;
          keys_valid_d = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pipe_empty_s) begin
          state_d = KEYLOAD;
          kidx_d  = 4'd0;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (in_valid && ready_s) begin
      eng_valid_d = 1'b1;
      eng_data_d  = in_data;
      eng_flag_d  = in_encrypt;
      mode_d      = in_encrypt;
    end else begin
      eng_valid_d = 1'b0;
    end
  end

  // Sequencer state and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      kidx_q       <= 4'd0;
      mode_q       <= 1'b1;
      keys_valid_q <= 1'b0;
      key_done_q   <= 1'b0;
      eng_load_q   <= 1'b0;
      eng_slot_q   <= 4'd0;
      eng_valid_q  <= 1'b0;
      eng_data_q   <= 128'd0;
      eng_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      kidx_q       <= kidx_d;
      mode_q       <= mode_d;
      keys_valid_q <= keys_valid_d;
      key_done_q   <= key_done_d;
      eng_load_q   <= eng_load_d;
      eng_slot_q   <= eng_slot_d;
      eng_valid_q  <= eng_valid_d;
      eng_data_q   <= eng_data_d;
      eng_flag_q   <= eng_flag_d;
    end
  end

  aes_inflight_tracker #(
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) u_tracker (
    .clk_i        (clk),
    .rst_ni       (n_rst),
    .issue_i      (eng_valid_q),
    .tag_i        (eng_flag_q),
    .tail_valid_o (tail_valid_s),
    .tail_tag_o   (tail_tag_s),
    .inflight_o   (inflight_s)
  );

  assign key_rd_addr      = ((state_q == KEYLOAD) && (kidx_q <= LAST_SLOT)) ? kidx_q : 4'd0;
  // Key store data arrives in the same cycle the slot strobe is presented
  assign eng_key          = eng_load_q ? key_rd_data : 128'd0;
  assign key_done         = key_done_q;
  assign keys_valid       = keys_valid_q;
  assign in_ready         = ready_s;
  assign eng_load         = eng_load_q;
  assign eng_round_number = eng_slot_q;
  assign eng_is_valid     = eng_valid_q;
  assign eng_data_in      = eng_data_q;
  assign eng_encrypt_flag = eng_flag_q;
  assign out_valid        = tail_valid_s;
  assign out_encrypt      = tail_valid_s & tail_tag_s;
  assign out_data         = tail_valid_s ? eng_data_out : 128'd0;

endmodule
